// File: rtl/bracket_scanner.sv
// bracket_scanner: walks instruction memory from a CBF/CBB branch to its matching bracket.
// Optional BRACKET_SCANNER_CHECK_EN aborts on depth overflow or a full address wrap.
module bracket_scanner #(
    parameter int PC_W = 8,
    parameter int DEPTH_W = 8,
    parameter int OP_W = 4,
    parameter logic [OP_W-1:0] OP_CBF = OP_W'(6),
    parameter logic [OP_W-1:0] OP_CBB = OP_W'(7)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            dir,
    input  logic [PC_W-1:0] start_pc,
    output logic            busy,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [OP_W-1:0] imem_data,
    input  logic            imem_valid,
    output logic            done,
    output logic [PC_W-1:0] target_pc,
    output logic            error
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
    state_e state_q, state_d;
    logic dir_q, dir_d;
    logic [PC_W-1:0] scan_pc_q, scan_pc_d, target_q, target_d, step_pc;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic open_br, close_br;
`ifdef BRACKET_SCANNER_CHECK_EN
    logic err_q, err_d;
    logic [PC_W-1:0] start_pc_q, start_pc_d;
`endif
    // "open" deepens the nest in the scan direction, "close" can match at depth 0
    assign open_br = dir_q ? (imem_data == OP_CBB) : (imem_data == OP_CBF);
    assign close_br = dir_q ? (imem_data == OP_CBF) : (imem_data == OP_CBB);
    assign step_pc = dir_q ? scan_pc_q - PC_ONE : scan_pc_q + PC_ONE;
    always_comb begin
        state_d = state_q;
        dir_d = dir_q;
        scan_pc_d = scan_pc_q;
        depth_d = depth_q;
        target_d = target_q;
`ifdef BRACKET_SCANNER_CHECK_EN
        err_d = err_q;
        start_pc_d = start_pc_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = REQ;
                dir_d = dir;
                scan_pc_d = dir ? start_pc - PC_ONE : start_pc + PC_ONE;
                depth_d = '0;
`ifdef BRACKET_SCANNER_CHECK_EN
                err_d = 1'b0;
                start_pc_d = start_pc;
`endif
            end
            REQ: state_d = WAIT;
            WAIT: if (imem_valid) begin
                if (close_br && depth_q == '0) begin
                    target_d = scan_pc_q + PC_ONE;
                    state_d = DONE;
                end else begin
                    depth_d = open_br ? depth_q + DEPTH_ONE : close_br ? depth_q - DEPTH_ONE : depth_q;
                    scan_pc_d = step_pc;
                    state_d = REQ;
`ifdef BRACKET_SCANNER_CHECK_EN
                    if ((open_br && depth_q == '1) || step_pc == start_pc_q) begin
                        target_d = start_pc_q;
                        err_d = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q <= 1'b0;
            scan_pc_q <= '0;
            depth_q <= '0;
            target_q <= '0;
`ifdef BRACKET_SCANNER_CHECK_EN
            err_q <= 1'b0;
            start_pc_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q <= dir_d;
            scan_pc_q <= scan_pc_d;
            depth_q <= depth_d;
            target_q <= target_d;
`ifdef BRACKET_SCANNER_CHECK_EN
            err_q <= err_d;
            start_pc_q <= start_pc_d;
`endif
        end
    end
    assign busy = state_q != IDLE;
    assign imem_req = state_q == REQ;
    assign imem_addr = scan_pc_q;
    assign done = state_q == DONE;
    assign target_pc = target_q;
`ifdef BRACKET_SCANNER_CHECK_EN
    assign error = err_q;
`else
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_bracket_scanner.sv
// tb_bracket_scanner: directed scans against a latency-configurable instruction memory model.
module tb_bracket_scanner;
    localparam logic [3:0] NOP = 4'h0;
    localparam logic [3:0] CBF = 4'h6;
    localparam logic [3:0] CBB = 4'h7;
    logic clock = 1'b0, reset = 1'b1, start = 1'b0, dir = 1'b0;
    logic [7:0] start_pc = '0;
    logic busy, imem_req, done, error, imem_valid;
    logic [7:0] imem_addr, target_pc;
    logic [3:0] imem_data;
    logic [3:0] mem [256];
    int cyc = 0, lat = 1, pend = 0, done_cnt = 0;
    logic [7:0] raddr = '0;
    int errors = 0, checks = 0;
    int fq[$];
    int rq[$];

    bracket_scanner dut (
        .clock(clock), .reset(reset), .start(start), .dir(dir), .start_pc(start_pc),
        .busy(busy), .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_valid(imem_valid), .done(done), .target_pc(target_pc), .error(error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clock);
            if (imem_req) begin
                fq.push_back(int'(imem_addr));
                rq.push_back(cyc);
                raddr = imem_addr;
                pend = lat;
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        imem_valid = 1'b0;
        imem_data = NOP;
        forever begin
            @(posedge clock);
            #1;
            imem_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    imem_valid = 1'b1;
                    imem_data = mem[raddr];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        fq.delete();
        rq.delete();
    endtask

    task automatic do_start(input logic [7:0] pc, input logic d, output int s);
        tick();
        start = 1'b1;
        start_pc = pc;
        dir = d;
        s = cyc;
        tick();
        start = 1'b0;
        start_pc = 8'hAA;
        dir = ~d;
    endtask

    task automatic wait_done(output int n);
        bit got = 0;
        n = -1;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clock);
            if (done) begin
                got = 1;
                n = cyc;
            end
        end
        check("done_seen", 32'(got), 1);
    endtask

    int s, n, d0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        tick();
        tick();
        @(negedge clock);
        check("rst_busy", 32'(busy), 0);
        check("rst_req", 32'(imem_req), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_done", 32'(done), 0);
        check("rst_target", 32'(target_pc), 0);
        check("rst_error", 32'(error), 0);
        tick();
        reset = 1'b0;

        clear_mem();
        mem[2] = CBB;
        lat = 1;
        do_start(8'd0, 1'b0, s);
        @(negedge clock);
        check("t1_busy", 32'(busy), 1);
        wait_done(n);
        check("t1_latency", 32'(n - s), 5);
        check("t1_target", 32'(target_pc), 3);
        check("t1_error", 32'(error), 0);
        check("t1_nfetch", 32'(fq.size()), 2);
        if (fq.size() == 2) begin
            check("t1_addr0", 32'(fq[0]), 1);
            check("t1_addr1", 32'(fq[1]), 2);
        end
        tick();
        tick();
        @(negedge clock);
        check("t1_idle", 32'(busy), 0);
        check("t1_hold", 32'(target_pc), 3);

        clear_mem();
        mem[1] = CBF;
        mem[2] = CBB;
        mem[3] = CBB;
        do_start(8'd0, 1'b0, s);
        wait_done(n);
        check("t2_latency", 32'(n - s), 7);
        check("t2_target", 32'(target_pc), 4);
        check("t2_nfetch", 32'(fq.size()), 3);

        clear_mem();
        mem[255] = CBF;
        mem[0] = NOP;
        do_start(8'd1, 1'b1, s);
        wait_done(n);
        check("t3_target", 32'(target_pc), 0);
        check("t3_nfetch", 32'(fq.size()), 2);
        if (fq.size() == 2) begin
            check("t3_addr0", 32'(fq[0]), 0);
            check("t3_addr1", 32'(fq[1]), 255);
        end

        clear_mem();
        mem[2] = CBB;
        mem[49] = CBF;
        lat = 3;
        d0 = done_cnt;
        do_start(8'd0, 1'b0, s);
        tick();
        start = 1'b1;
        start_pc = 8'd50;
        dir = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("t4_latency", 32'(n - s), 9);
        check("t4_target", 32'(target_pc), 3);
        check("t4_nfetch", 32'(fq.size()), 2);
        if (rq.size() == 2) check("t4_spacing", 32'(rq[1] - rq[0]), 4);
        for (int i = 0; i < 4; i++) tick();
        check("t4_one_done", 32'(done_cnt - d0), 1);

        clear_mem();
        mem[1] = CBF;
        mem[3] = CBB;
        mem[4] = CBB;
        lat = 1;
        do_start(8'd0, 1'b0, s);
        tick();
        reset = 1'b1;
        d0 = done_cnt;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("t5_busy", 32'(busy), 0);
        check("t5_req", 32'(imem_req), 0);
        check("t5_done", 32'(done), 0);
        for (int i = 0; i < 6; i++) tick();
        check("t5_no_done", 32'(done_cnt - d0), 0);
        fq.delete();
        do_start(8'd0, 1'b0, s);
        wait_done(n);
        check("t5_target", 32'(target_pc), 5);
        check("t5_latency", 32'(n - s), 9);

`ifdef BRACKET_SCANNER_CHECK_EN
        clear_mem();
        do_start(8'd10, 1'b0, s);
        wait_done(n);
        check("t6_error", 32'(error), 1);
        check("t6_target", 32'(target_pc), 10);
        check("t6_nfetch", 32'(fq.size()), 255);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
